alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational 8-bit ALU (y = f(opcode, a, b)) between NREQ requesters.
//  Round-robin grant with a valid/ready handshake per requester. Operands are registered onto the ALU inputs.
//  The result is captured one cycle later and returned with the requester ID over a valid/ready response port.
//  Sits between requester blocks and the ALU instance. The ALU's ports connect to alu_op/alu_a/alu_b/alu_y.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  W      8   operand/result width
//  OPW    3   opcode width
//  IDW    2   requester ID width, must equal clog2(NREQ)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   NREQ      request pending, bit i = requester i
//  req_op     in   NREQ*OPW  packed opcodes; slice i = [i*OPW +: OPW]
//  req_a      in   NREQ*W    packed operand a
//  req_b      in   NREQ*W    packed operand b
//  req_ready  out  NREQ      one-hot grant; handshake = req_valid[i] & req_ready[i]
//  alu_op     out  OPW       registered opcode to ALU
//  alu_a      out  W         registered operand a to ALU
//  alu_b      out  W         registered operand b to ALU
//  alu_y      in   W         ALU result (combinational from alu_op/a/b)
//  rsp_valid  out  1         result available
//  rsp_y      out  W         captured result
//  rsp_id     out  IDW       index of the requester that owns rsp_y
//  rsp_ready  in   1         consumer accepts response
//  busy       out  1         high in any state other than IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; alu_op/alu_a/alu_b/rsp_y/rsp_id=0; rsp_valid=0; ptr=NREQ-1.
//  - FSM: IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: if req_valid!=0, grant g = first set bit searching from (ptr+1) mod NREQ upward, with wrap.
//    req_ready[g]=1 combinationally in the same cycle; all other bits are 0.
//    On that edge: latch op/a/b slice g into alu_*; rsp_id<=g; ptr<=g; go to EXEC.
//    If req_valid==0, stay in IDLE; req_ready=0.
//  - EXEC: one cycle, with the ALU settling on the registered inputs.
//    On the edge: rsp_y<=alu_y; rsp_valid<=1; go to RESP.
//  - RESP: rsp_valid, rsp_y and rsp_id are held stable until rsp_valid&rsp_ready.
//    On that edge: rsp_valid<=0; go to IDLE. No new grant in this cycle.
//  - req_ready=0 in EXEC and RESP. alu_* hold their values until the next grant.
//  - Latency: grant edge to rsp_valid is 2 cycles. Minimum 3 cycles per operation.
//  - Requesters must hold req_valid and operands stable until their handshake.
//    Dropping valid before grant is allowed; that requester is skipped.
//  - Simultaneous requests: only one grant per IDLE cycle. Others wait; ptr guarantees each is served within NREQ grants.
//  - ptr wraps from NREQ-1 to 0. With a single requester active, it is re-granted every time.
//  - rsp_ready high while not in RESP is ignored.
//  - Reset mid-operation discards the in-flight op and the response. After reset, the grant search starts from requester 0.
// CONFIGURATION
//  ALU_ARB_PRIO_EN defined: requester 0 has absolute priority.
//    In IDLE, req_valid[0] wins regardless of ptr; ptr is not updated for such a grant.
//    Requesters 1..NREQ-1 are round-robin among themselves.
//  ALU_ARB_PRIO_EN undefined: pure round-robin over all NREQ, as described above.
// TESTING
//  1. Reset, with req_valid=4'b0010, op[1]=3'h2, a[1]=8'h12, b[1]=8'h34 ->
//     req_ready=4'b0010 in that cycle; next cycle alu_op=3'h2, alu_a=8'h12, alu_b=8'h34.
//     Two cycles after the grant: rsp_valid=1, rsp_id=1, rsp_y=alu_y.
//  2. req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0.
//     rsp_id follows the same sequence, one op per 3 cycles.
//  3. One op in flight, rsp_ready=0 for 5 cycles -> rsp_valid/rsp_y/rsp_id stay stable; req_ready=0 throughout.
//     Then rsp_ready=1 -> rsp_valid drops next edge; next grant one cycle later.
//  4. Last grant=3, req_valid=4'b1001 -> next grant is requester 0 (wrap), then requester 3.
//  5. Assert rst_n=0 while in EXEC -> all outputs 0 immediately; rsp_valid never asserts for that op.
//     After release with req_valid=4'b1100 -> first grant is requester 2.
//  6. ALU_ARB_PRIO_EN defined, req_valid=4'b0111 held -> grants 0,0,0.
//     Then drop bit 0 -> grants 1,2,1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Optional macro ALU_ARB_PRIO_EN: requester 0 gets absolute priority.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req_valid/ready    per-requester handshake (ready is one-hot grant)
//   req_op/a/b         packed per-requester opcode and operands
//   alu_op/a/b, alu_y  registered operands to ALU, ALU result back
//   rsp_valid/ready    response handshake, with rsp_y and rsp_id
//   busy               high outside IDLE
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int OPW  = 3,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*OPW-1:0] req_op,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [OPW-1:0]    alu_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_y,
    output logic              rsp_valid,
    output logic [W-1:0]      rsp_y,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_ptr;
    logic [OPW-1:0]  r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_y;
    logic [IDW-1:0]  r_id;
    logic            r_valid;
    logic [NREQ-1:0] w_cand;
    logic [IDW-1:0]  w_gidx;
    logic            w_found;
    logic            w_take;

`ifdef ALU_ARB_PRIO_EN
    logic w_prio;
    // Requester 0 is outside the rotation; it preempts it entirely.
    assign w_prio = req_valid[0];
    assign w_cand = req_valid & ~NREQ'(1);
`else
    assign w_cand = req_valid;
`endif

    // First candidate strictly after the last grant, with wrap.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(r_ptr) + k) % NREQ;
            if (!w_found && w_cand[IDW'(j)]) begin
                w_found = 1'b1;
                w_gidx  = IDW'(j);
            end
        end
`ifdef ALU_ARB_PRIO_EN
        if (w_prio) begin
            w_found = 1'b1;
            w_gidx  = '0;
        end
`endif
    end

    // Grant is also masked by rst_n so all outputs read 0 during reset.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_take    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found && rst_n) begin
                    w_take    = 1'b1;
                    req_ready = NREQ'(1) << w_gidx;
                    w_next    = S_EXEC;
                end
            end
            S_EXEC: w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= IDW'(NREQ - 1);
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_op <= req_op[int'(w_gidx)*OPW +: OPW];
                r_a  <= req_a[int'(w_gidx)*W +: W];
                r_b  <= req_b[int'(w_gidx)*W +: W];
                r_id <= w_gidx;
`ifdef ALU_ARB_PRIO_EN
                if (!w_prio) r_ptr <= w_gidx;
`else
                r_ptr <= w_gidx;
`endif
            end
            if (r_state == S_EXEC) begin
                r_y     <= alu_y;
                r_valid <= 1'b1;
            end
            if (r_state == S_RESP && rsp_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rsp_y     = r_y;
    assign rsp_id    = r_id;
    assign rsp_valid = r_valid;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model on alu_y.
// Define ALU_ARB_PRIO_EN to run the priority scenario instead of pure RR ones.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int OPW  = 3;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*OPW-1:0]  req_op = '0;
    logic [NREQ*W-1:0]    req_a = '0;
    logic [NREQ*W-1:0]    req_b = '0;
    logic [NREQ-1:0]      req_ready;
    logic [OPW-1:0]       alu_op;
    logic [W-1:0]         alu_a;
    logic [W-1:0]         alu_b;
    logic [W-1:0]         alu_y;
    logic                 rsp_valid;
    logic [W-1:0]         rsp_y;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_ready = 1'b1;
    logic                 busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .W(W), .OPW(OPW), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always_comb begin
        alu_y = '0;
        case (alu_op)
            3'd0: alu_y = alu_a + alu_b;
            3'd1: alu_y = alu_a - alu_b;
            3'd2: alu_y = alu_a & alu_b;
            3'd3: alu_y = alu_a | alu_b;
            3'd4: alu_y = alu_a ^ alu_b;
            3'd5: alu_y = ~alu_a;
            3'd6: alu_y = alu_a << 1;
            default: alu_y = alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // r0: add 10+05=15, r1: sub 20-01=1F, r2: xor F0^0F=FF, r3: or 81|02=83
    task automatic set_ops();
        req_op = {3'd3, 3'd4, 3'd1, 3'd0};
        req_a  = {8'h81, 8'hF0, 8'h20, 8'h10};
        req_b  = {8'h02, 8'h0F, 8'h01, 8'h05};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entered at the negedge of an IDLE cycle; leaves at the RESP negedge.
    task automatic serve(input int id, input logic [7:0] y);
        #1;
        check("grant", req_ready, 32'(1 << id));
        @(negedge clk);
        check("exec_ready", req_ready, 0);
        check("exec_valid", rsp_valid, 0);
        check("exec_busy", busy, 1);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_y", rsp_y, y);
    endtask

    initial begin
        set_ops();
        // Reset values while rst_n is low
        #2;
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp_id", rsp_id, 0);
        do_reset();

        // 1: single request from requester 1, AND 12&34=10
        req_op[1*OPW +: OPW] = 3'h2;
        req_a[1*W +: W]      = 8'h12;
        req_b[1*W +: W]      = 8'h34;
        req_valid            = 4'b0010;
        #1;
        check("t1_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        check("t1_alu_op", alu_op, 3'h2);
        check("t1_alu_a", alu_a, 8'h12);
        check("t1_alu_b", alu_b, 8'h34);
        check("t1_early_valid", rsp_valid, 0);
        @(negedge clk);
        check("t1_valid", rsp_valid, 1);
        check("t1_id", rsp_id, 1);
        check("t1_y", rsp_y, 8'h10);
        set_ops();

`ifndef ALU_ARB_PRIO_EN
        // 2: all requesting, order 0,1,2,3,0
        do_reset();
        req_valid = 4'b1111;
        serve(0, 8'h15); @(negedge clk);
        serve(1, 8'h1F); @(negedge clk);
        serve(2, 8'hFF); @(negedge clk);
        serve(3, 8'h83); @(negedge clk);
        serve(0, 8'h15);

        // 4: last grant 3, then 1001 -> 0 then 3
        do_reset();
        req_valid = 4'b1000;
        serve(3, 8'h83); @(negedge clk);
        req_valid = 4'b1001;
        serve(0, 8'h15); @(negedge clk);
        serve(3, 8'h83);
`endif

        // 3: response backpressure for 5 cycles
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        serve(2, 8'hFF);
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", rsp_valid, 1);
            check("t3_hold_y", rsp_y, 8'hFF);
            check("t3_hold_id", rsp_id, 2);
            check("t3_hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_drop", rsp_valid, 0);
        check("t3_next_grant", req_ready, 4'b0001);
        req_valid = '0;

        // 5: reset during EXEC discards the op
        do_reset();
        req_valid = 4'b0001;
        #1;
        check("t5_grant", req_ready, 4'b0001);
        @(negedge clk);
        check("t5_in_exec", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", rsp_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_alu_a", alu_a, 0);
        check("t5_rst_ready", req_ready, 0);
        req_valid = 4'b1100;
        @(negedge clk);
        check("t5_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        serve(2, 8'hFF);

`ifdef ALU_ARB_PRIO_EN
        // 6: requester 0 wins always, others round-robin
        do_reset();
        req_valid = 4'b0111;
        serve(0, 8'h15); @(negedge clk);
        serve(0, 8'h15); @(negedge clk);
        serve(0, 8'h15); @(negedge clk);
        req_valid = 4'b0110;
        serve(1, 8'h1F); @(negedge clk);
        serve(2, 8'hFF); @(negedge clk);
        serve(1, 8'h1F);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
